// File: rtl/mips_mem_arbiter.sv
// Arbitrates IF fetches and MEM-stage loads/stores onto one fixed-latency memory port.
// Optional stall-cycle counters are enabled by defining MEM_ARB_PERF_EN.
module mips_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_if,
  output logic              stall_mem
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]       perf_if_stall,
  output logic [31:0]       perf_dm_stall
`endif
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [3:0] LAT = 4'(MEM_LAT);

  logic [1:0]        r_state;
  logic              r_owner_dm;
  logic              r_if_owed;
  logic [3:0]        r_cnt;
  logic              r_mem_en;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_dm_rdata;
  logic              r_if_ack;
  logic              r_dm_ack;

  logic w_grant_dm;
  logic w_grant_if;

  // Data wins ties unless fetch was already passed over once while waiting.
  assign w_grant_dm = dm_req & ~(r_if_owed & if_req);
  assign w_grant_if = ~w_grant_dm & if_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_owner_dm  <= 1'b0;
      r_if_owed   <= 1'b0;
      r_cnt       <= '0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_rdata  <= '0;
      r_dm_rdata  <= '0;
      r_if_ack    <= 1'b0;
      r_dm_ack    <= 1'b0;
    end else begin
      r_mem_en <= 1'b0;
      r_if_ack <= 1'b0;
      r_dm_ack <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_grant_dm) begin
            r_owner_dm  <= 1'b1;
            r_mem_we    <= dm_we;
            r_mem_addr  <= dm_addr;
            r_mem_wdata <= dm_wdata;
            r_mem_en    <= 1'b1;
            r_state     <= S_ISSUE;
            if (if_req) begin
              r_if_owed <= 1'b1;
            end
          end else if (w_grant_if) begin
            r_owner_dm  <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= if_addr;
            r_mem_wdata <= '0;
            r_mem_en    <= 1'b1;
            r_if_owed   <= 1'b0;
            r_state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_cnt   <= LAT;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          // The count hits 1 in the cycle the memory data is valid, so capture here.
          if (r_cnt == 4'd1) begin
            if (r_owner_dm) begin
              if (!r_mem_we) begin
                r_dm_rdata <= mem_rdata;
              end
              r_dm_ack <= 1'b1;
            end else begin
              r_if_rdata <= mem_rdata;
              r_if_ack   <= 1'b1;
            end
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign if_rdata  = r_if_rdata;
  assign dm_rdata  = r_dm_rdata;
  assign if_ack    = r_if_ack;
  assign dm_ack    = r_dm_ack;
  assign stall_if  = if_req & ~r_if_ack;
  assign stall_mem = dm_req & ~r_dm_ack;

`ifdef MEM_ARB_PERF_EN
  logic [31:0] r_perf_if;
  logic [31:0] r_perf_dm;

  // Saturating counters so a long-running core never wraps back to small values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_if <= '0;
      r_perf_dm <= '0;
    end else begin
      if (stall_if && (r_perf_if != 32'hFFFF_FFFF)) begin
        r_perf_if <= r_perf_if + 32'd1;
      end
      if (stall_mem && (r_perf_dm != 32'hFFFF_FFFF)) begin
        r_perf_dm <= r_perf_dm + 32'd1;
      end
    end
  end

  assign perf_if_stall = r_perf_if;
  assign perf_dm_stall = r_perf_dm;
`endif

endmodule
